// File: rtl/parity_check_arbiter_if.sv
// Request/result bundle between four nibble sources and the shared parity-check arbiter.
// The master side drives requests; the slave side (the arbiter) returns grants, results and counters.
interface parity_check_arbiter_if #(
    parameter int CNT_W = 8
);
    logic                 en;
    logic                 clr_cnt;
    logic [3:0]           req;
    logic [15:0]          data_in;
    logic [3:0]           ack;
    logic                 busy;
    logic                 res_valid;
    logic [1:0]           res_id;
    logic                 res_err;
    logic [4*CNT_W-1:0]   err_cnt;

    modport master (
        output en, clr_cnt, req, data_in,
        input  ack, busy, res_valid, res_id, res_err, err_cnt
    );

    modport slave (
        input  en, clr_cnt, req, data_in,
        output ack, busy, res_valid, res_id, res_err, err_cnt
    );
endinterface

// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one 4-bit parity checker between four requesters,
// with a tagged one-cycle result strobe and saturating per-requester error counters.
module parity_check_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    parity_check_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, CHECK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       hold_data_q, hold_data_d;
    logic [1:0]       hold_id_q, hold_id_d;
    logic [3:0]       ack_q, ack_d;
    logic             res_valid_q, res_valid_d;
    logic [1:0]       res_id_q, res_id_d;
    logic             res_err_q, res_err_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    logic             found;
    logic [1:0]       win;
    logic [1:0]       idx;

    // Scan from the stored pointer upward with wrap; the first set request wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_data_d = hold_data_q;
        hold_id_d   = hold_id_q;
        ack_d       = '0;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_err_d   = res_err_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.en && found) begin
                    state_d     = CHECK;
                    hold_data_d = bus.data_in[{win, 2'b00} +: 4];
                    hold_id_d   = win;
                    ack_d       = 4'b0001 << win;
                end
            end
            CHECK: begin
                state_d     = IDLE;
                res_valid_d = 1'b1;
                res_id_d    = hold_id_q;
                res_err_d   = ^hold_data_q;
                ptr_d       = hold_id_q + 2'd1;
                if (^hold_data_q && cnt_q[hold_id_q] != CNT_MAX)
                    cnt_d[hold_id_q] = cnt_q[hold_id_q] + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Clear takes priority over an increment landing on the same edge.
        if (bus.clr_cnt)
            for (int i = 0; i < 4; i++) cnt_d[i] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_data_q <= '0;
            hold_id_q   <= '0;
            ack_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_err_q   <= 1'b0;
            // NOTE: the counter array is architecturally visible, so it is reset like any other register.
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_data_q <= hold_data_d;
            hold_id_q   <= hold_id_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_err_q   <= res_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.busy      = (state_q == CHECK);
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_err   = res_err_q;

    for (genvar i = 0; i < 4; i++) begin : g_cnt_out
        assign bus.err_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
    end
endmodule

// File: tb/tb_parity_check_arbiter.sv
// Self-checking bench for parity_check_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_parity_check_arbiter;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    parity_check_arbiter_if #(.CNT_W(CNT_W)) bus ();

    parity_check_arbiter #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending check (-1 when none), rotating priority, counters as integers.
    int         m_pend;
    logic [3:0] m_pdata;
    int         m_ptr;
    int         m_cnt [4];
    logic [3:0] m_ack;
    bit         m_rv;
    int         m_rid;
    bit         m_rerr;

    int         cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend  = -1;
        m_pdata = '0;
        m_ptr   = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_ack   = '0;
        m_rv    = 1'b0;
        m_rid   = 0;
        m_rerr  = 1'b0;
    endtask

    task automatic model_edge();
        int g;
        m_ack = '0;
        m_rv  = 1'b0;
        if (m_pend >= 0) begin
            m_rv   = 1'b1;
            m_rid  = m_pend;
            m_rerr = ($countones(m_pdata) % 2) == 1;
            if (m_rerr && m_cnt[m_pend] < CMAX) m_cnt[m_pend]++;
            m_ptr  = (m_pend + 1) % 4;
            m_pend = -1;
        end else if (bus.en && bus.req != 4'b0) begin
            g = m_ptr;
            for (int k = 0; k < 4; k++) begin
                g = (m_ptr + k) % 4;
                if (bus.req[g]) break;
            end
            m_pend  = g;
            m_pdata = bus.data_in[4*g +: 4];
            m_ack   = 4'(1 << g);
        end
        if (bus.clr_cnt) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic compare_all();
        logic [4*CNT_W-1:0] e;
        for (int i = 0; i < 4; i++) e[CNT_W*i +: CNT_W] = CNT_W'(m_cnt[i]);
        check("ack",       32'(bus.ack),       32'(m_ack));
        check("busy",      32'(bus.busy),      32'(m_pend >= 0));
        check("res_valid", 32'(bus.res_valid), 32'(m_rv));
        check("res_id",    32'(bus.res_id),    32'(m_rid));
        check("res_err",   32'(bus.res_err),   32'(m_rerr));
        check("err_cnt",   32'(bus.err_cnt),   32'(e));
    endtask

    // One clock edge: advance the model with the inputs the DUT sees, then compare just after the edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.en      = 1'b1;
        bus.clr_cnt = 1'b0;
        bus.req     = '0;
        bus.data_in = '0;
    endtask

    // Called just after an edge; reset is asserted and released between edges.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int id);
        return bus.err_cnt[CNT_W*id +: CNT_W];
    endfunction

    // Single request on one requester, result edge follows; clr_cnt optionally asserted on the result edge.
    task automatic one_req(input int id, input logic [3:0] nib, input bit clr_on_result);
        bus.req = 4'(1 << id);
        bus.data_in = '0;
        bus.data_in[4*id +: 4] = nib;
        cycle();
        check("one_req_ack", 32'(bus.ack), 32'(1 << id));
        bus.req = '0;
        bus.clr_cnt = clr_on_result;
        cycle();
        bus.clr_cnt = 1'b0;
        check("one_req_valid", 32'(bus.res_valid), 32'd1);
        check("one_req_id", 32'(bus.res_id), 32'(id));
    endtask

    initial begin
        int order [$];
        int ack_cyc [$];
        logic [CNT_W-1:0] c1;
        cyc = 0;
        idle_inputs();
        rst_n = 1'b1;
        #1;
        do_reset();

        // Reset state
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        check("rst_cnt", 32'(bus.err_cnt), 32'd0);

        // Single request on requester 2 with odd-parity data
        bus.req = 4'b0100;
        bus.data_in[11:8] = 4'b1011;
        cycle();
        check("single_ack", 32'(bus.ack), 32'b0100);
        check("single_busy", 32'(bus.busy), 32'd1);
        bus.req = '0;
        cycle();
        check("single_valid", 32'(bus.res_valid), 32'd1);
        check("single_id", 32'(bus.res_id), 32'd2);
        check("single_err", 32'(bus.res_err), 32'd1);
        check("single_cnt2", 32'(cnt_of(2)), 32'd1);
        check("single_ack_clr", 32'(bus.ack), 32'd0);

        // Round-robin fairness from a fresh pointer
        do_reset();
        bus.req = 4'b1111;
        bus.data_in = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus.ack != 4'b0) begin
                for (int b = 0; b < 4; b++) if (bus.ack[b]) order.push_back(b);
                ack_cyc.push_back(cyc);
            end
        end
        bus.req = '0;
        cycle();
        check("rr_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) check("rr_order", 32'(order[i]), 32'(i % 4));
        for (int i = 1; i < ack_cyc.size(); i++) check("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);

        // Even-parity data never flags an error
        c1 = cnt_of(1);
        one_req(1, 4'b0000, 1'b0);
        check("even0_err", 32'(bus.res_err), 32'd0);
        one_req(1, 4'b0011, 1'b0);
        check("even3_err", 32'(bus.res_err), 32'd0);
        one_req(1, 4'b1111, 1'b0);
        check("evenF_err", 32'(bus.res_err), 32'd0);
        check("even_cnt1", 32'(cnt_of(1)), 32'(c1));

        // Saturation then clear colliding with an error result
        one_req(3, 4'b0001, 1'b0);
        one_req(3, 4'b0111, 1'b0);
        one_req(3, 4'b1000, 1'b0);
        check("sat_cnt3_3", 32'(cnt_of(3)), 32'd3);
        one_req(3, 4'b1110, 1'b0);
        check("sat_cnt3_hold", 32'(cnt_of(3)), 32'd3);
        one_req(3, 4'b0100, 1'b1);
        check("clr_err", 32'(bus.res_err), 32'd1);
        check("clr_cnt3", 32'(cnt_of(3)), 32'd0);

        // Enable gating
        bus.en = 1'b0;
        bus.req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("en_gate_ack", 32'(bus.ack), 32'd0);
        end
        bus.en = 1'b1;
        cycle();
        check("en_rise_ack", 32'(bus.ack), 32'b0001);

        // Dropping en during CHECK still delivers the result
        bus.en = 1'b0;
        bus.req = '0;
        cycle();
        check("en_drop_valid", 32'(bus.res_valid), 32'd1);
        check("en_drop_id", 32'(bus.res_id), 32'd0);
        bus.en = 1'b1;

        // Reset in the cycle after ack discards the pending result
        bus.req = 4'b0100;
        bus.data_in = 16'h0700;
        cycle();
        check("midrst_ack", 32'(bus.ack), 32'b0100);
        bus.req = '0;
        do_reset();
        cycle();
        check("midrst_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_cnt", 32'(bus.err_cnt), 32'd0);
        bus.req = 4'b1111;
        cycle();
        check("midrst_next", 32'(bus.ack), 32'b0001);
        bus.req = '0;
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.en      = ($urandom_range(0, 7) != 0);
            bus.req     = 4'($urandom);
            bus.data_in = 16'($urandom);
            bus.clr_cnt = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
        end
        idle_inputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
